// File: rtl/conv_pkg.sv
// Shared constants and types for the convolution core OFM path.
package conv_pkg;

  localparam int unsigned NUM_CH        = 16;
  localparam int unsigned BYTE_W        = 8;
  localparam int unsigned WORD_W        = 64;
  localparam int unsigned WORDS_PER_PIX = 2;
  localparam int unsigned PIX_W         = WORD_W * WORDS_PER_PIX;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_WR_LO,
    ST_WR_HI,
    ST_DONE
  } state_e;

  // Low half carries ch0..ch7, high half ch8..ch15.
  function automatic logic [WORD_W-1:0] pix_half(input logic [PIX_W-1:0] pix,
                                                 input logic             hi);
    return hi ? pix[PIX_W-1:WORD_W] : pix[WORD_W-1:0];
  endfunction

endpackage

// File: rtl/ofm_pixel_reg.sv
// 128-bit pixel holding register with a lo/hi 64-bit word select.
module ofm_pixel_reg
  import conv_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              sel,
  input  logic [PIX_W-1:0]  din,
  output logic [WORD_W-1:0] dout
);

  logic [PIX_W-1:0] pix_q;
  logic [PIX_W-1:0] pix_d;

  // Next pixel value: capture on load, otherwise hold.
  always_comb begin
    pix_d = load ? din : pix_q;
  end

  // Pixel storage register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pix_q <= '0;
    else        pix_q <= pix_d;
  end

  assign dout = pix_half(pix_q, sel);

endmodule

// File: rtl/ofm_pack_writer.sv
// Packs 16-channel OFM pixels into two 64-bit BRAM writes and counts the layer.
module ofm_pack_writer
  import conv_pkg::*;
#(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned NUM_PIXELS = 3136
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       clear,
  input  logic [ADDR_W-1:0]          base_addr,
  input  logic                       ofm_valid,
  output logic                       ofm_ready,
  input  logic [NUM_CH*BYTE_W-1:0]   ofm_data,
  output logic                       wr_en,
  input  logic                       wr_ready,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic [WORD_W-1:0]          wr_data,
  output logic                       busy,
  output logic                       done,
  output logic [15:0]                pix_count
);

  localparam logic [15:0] LAST_COUNT = 16'(NUM_PIXELS);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [15:0]         pix_count_q, pix_count_d;
  logic                wr_en_q, wr_en_d;
  logic                ofm_ready_q, ofm_ready_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pix_load;
  logic                pix_sel;
  logic [WORD_W-1:0]   pix_word;

  ofm_pixel_reg u_pixel_reg (
    .clk   (clk),
    .rst_n (reset),
    .load  (pix_load),
    .sel   (pix_sel),
    .din   (ofm_data),
    .dout  (pix_word)
  );

  // Next state, counters and output registers; outputs are decoded from the
  // next state so they line up with the state register.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    pix_count_d = pix_count_q;
    pix_load    = 1'b0;

    if (clear) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d     = ST_CAPTURE;
            addr_d      = base_addr;
            pix_count_d = '0;
          end
        end
        ST_CAPTURE: begin
          if (ofm_valid) begin
            pix_load = 1'b1;
            state_d  = ST_WR_LO;
          end
        end
        ST_WR_LO: begin
          if (wr_ready) begin
            addr_d  = addr_q + ADDR_W'(1);
            state_d = ST_WR_HI;
          end
        end
        ST_WR_HI: begin
          if (wr_ready) begin
            addr_d      = addr_q + ADDR_W'(1);
            pix_count_d = pix_count_q + 16'd1;
            state_d     = (pix_count_d == LAST_COUNT) ? ST_DONE : ST_CAPTURE;
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    ofm_ready_d = (state_d == ST_CAPTURE);
    wr_en_d     = (state_d == ST_WR_LO) || (state_d == ST_WR_HI);
    busy_d      = (state_d != ST_IDLE);
    done_d      = (state_d == ST_DONE);
    wr_addr_d   = wr_en_d ? addr_d : wr_addr_q;
  end

  // FSM, counters and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      wr_addr_q   <= '0;
      pix_count_q <= '0;
      wr_en_q     <= 1'b0;
      ofm_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wr_addr_q   <= wr_addr_d;
      pix_count_q <= pix_count_d;
      wr_en_q     <= wr_en_d;
      ofm_ready_q <= ofm_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign pix_sel   = (state_q == ST_WR_HI);
  assign wr_data   = wr_en_q ? pix_word : '0;
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign ofm_ready = ofm_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pix_count = pix_count_q;

endmodule

// File: tb/tb_ofm_pack_writer.sv
// Self-checking bench for ofm_pack_writer: a short-layer instance for directed
// scenarios and a full 56x56 instance for the randomized layer run.
module tb_ofm_pack_writer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         clear;
  logic [15:0]  base_addr;
  logic         ofm_valid;
  logic [127:0] ofm_data;
  logic         wr_ready;

  logic         s_ofm_ready, s_wr_en, s_busy, s_done;
  logic [15:0]  s_wr_addr, s_pix_count;
  logic [63:0]  s_wr_data;
  logic         l_ofm_ready, l_wr_en, l_busy, l_done;
  logic [15:0]  l_wr_addr, l_pix_count;
  logic [63:0]  l_wr_data;

  int unsigned  checks = 0;
  int unsigned  errors = 0;
  logic [127:0] pix_mem [0:3135];

  always #5 clk = ~clk;

  ofm_pack_writer #(.ADDR_W(16), .NUM_PIXELS(2)) dut_s (
    .clk(clk), .reset(rst_n), .start(start), .clear(clear), .base_addr(base_addr),
    .ofm_valid(ofm_valid), .ofm_ready(s_ofm_ready), .ofm_data(ofm_data),
    .wr_en(s_wr_en), .wr_ready(wr_ready), .wr_addr(s_wr_addr), .wr_data(s_wr_data),
    .busy(s_busy), .done(s_done), .pix_count(s_pix_count)
  );

  ofm_pack_writer #(.ADDR_W(16), .NUM_PIXELS(3136)) dut_l (
    .clk(clk), .reset(rst_n), .start(start), .clear(clear), .base_addr(base_addr),
    .ofm_valid(ofm_valid), .ofm_ready(l_ofm_ready), .ofm_data(ofm_data),
    .wr_en(l_wr_en), .wr_ready(wr_ready), .wr_addr(l_wr_addr), .wr_data(l_wr_data),
    .busy(l_busy), .done(l_done), .pix_count(l_pix_count)
  );

  // Word 'half' of a pixel: byte b of the word is channel 8*half+b.
  function automatic logic [63:0] exp_word(input logic [127:0] pix, input int unsigned half);
    logic [63:0] w;
    w = '0;
    for (int unsigned b = 0; b < 8; b++) w[8*b +: 8] = pix[8*(8*half + b) +: 8];
    return w;
  endfunction

  function automatic logic [127:0] rand_pix();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; start = 1'b0; clear = 1'b0; base_addr = '0;
    ofm_valid = 1'b0; ofm_data = '0; wr_ready = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    bit hit;
    rst_n = 1'b0; start = 1'b0; clear = 1'b0; base_addr = '0;
    ofm_valid = 1'b0; ofm_data = '0; wr_ready = 1'b0;
    step();
    @(negedge clk);
    checks++;
    if ({s_ofm_ready, s_wr_en, s_busy, s_done} !== 4'b0 || s_wr_addr !== 16'h0 ||
        s_wr_data !== 64'h0 || s_pix_count !== 16'h0) begin
      errors++;
      $display("FAIL reset_idle: rdy=%b en=%b busy=%b done=%b addr=%h data=%h cnt=%0d, required all 0",
               s_ofm_ready, s_wr_en, s_busy, s_done, s_wr_addr, s_wr_data, s_pix_count);
    end
    step();
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (s_ofm_ready !== 1'b0 || s_busy !== 1'b0) begin
        errors++;
        $display("FAIL ready_before_start: rdy=%b busy=%b, required 0 0", s_ofm_ready, s_busy);
      end
    end
    step();
    base_addr = 16'h0040; start = 1'b1;
    step();
    start = 1'b0; ofm_valid = 1'b1; ofm_data = rand_pix(); wr_ready = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 10 && !hit; i++) begin
      @(negedge clk);
      if (s_wr_en === 1'b1 && s_wr_addr === 16'h0041) hit = 1'b1;
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL reach_wr_hi: hi word at 0x0041 not seen within 10 cycles");
    end
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({s_ofm_ready, s_wr_en, s_busy, s_done} !== 4'b0 || s_wr_addr !== 16'h0 ||
          s_wr_data !== 64'h0 || s_pix_count !== 16'h0) begin
        errors++;
        $display("FAIL reset_mid_hi[%0d]: rdy=%b en=%b busy=%b done=%b addr=%h data=%h cnt=%0d, required all 0",
                 k, s_ofm_ready, s_wr_en, s_busy, s_done, s_wr_addr, s_wr_data, s_pix_count);
      end
      @(negedge clk);
    end
    ofm_valid = 1'b0; wr_ready = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    @(negedge clk);
    checks++;
    if (s_ofm_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_after_release: got %b required 0", s_ofm_ready);
    end
  endtask

  task automatic test_two_pixels();
    int unsigned commits = 0, dones = 0, sent = 0;
    int          last_commit = -100, done_at = -1, acc_cyc = -1, first_wr = -1;
    int          commit_cyc [4];
    logic [63:0] got_d [4];
    logic [15:0] exp_a;
    logic [63:0] exp_d;
    bit          acc;
    apply_reset();
    for (int unsigned c = 0; c < 16; c++) begin
      pix_mem[0][8*c +: 8] = 8'(c);
      pix_mem[1][8*c +: 8] = 8'(c + 16);
    end
    base_addr = 16'h0100; wr_ready = 1'b1; start = 1'b1;
    step();
    start = 1'b0; ofm_valid = 1'b1; ofm_data = pix_mem[0];
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      acc = s_ofm_ready && ofm_valid;
      if (acc && acc_cyc < 0) acc_cyc = cyc;
      if (s_wr_en && first_wr < 0) first_wr = cyc;
      if (s_wr_en && wr_ready) begin
        exp_a = 16'(32'h0100 + commits);
        exp_d = exp_word(pix_mem[(commits / 2) % 2], commits % 2);
        checks++;
        if (commits >= 4 || s_wr_addr !== exp_a || s_wr_data !== exp_d) begin
          errors++;
          $display("FAIL two_pix_write[%0d]: got %h@%h required %h@%h",
                   commits, s_wr_data, s_wr_addr, exp_d, exp_a);
        end
        if (commits < 4) begin
          commit_cyc[commits] = cyc;
          got_d[commits] = s_wr_data;
        end
        commits++;
        last_commit = cyc;
      end
      if (s_done) begin
        dones++;
        done_at = cyc;
      end
      step();
      if (acc) begin
        sent++;
        if (sent < 2) ofm_data = pix_mem[sent];
        else          ofm_valid = 1'b0;
      end
    end
    checks++;
    if (commits != 4) begin
      errors++; $display("FAIL two_pix_count: got %0d writes required 4", commits);
    end
    checks++;
    if (dones != 1 || done_at != last_commit + 1) begin
      errors++;
      $display("FAIL two_pix_done: got %0d pulses at cycle %0d required 1 at cycle %0d",
               dones, done_at, last_commit + 1);
    end
    checks++;
    if (s_pix_count !== 16'd2 || s_busy !== 1'b0) begin
      errors++;
      $display("FAIL two_pix_final: cnt=%0d busy=%b required 2 0", s_pix_count, s_busy);
    end
    checks++;
    if (first_wr != acc_cyc + 1) begin
      errors++;
      $display("FAIL latency: first word at cycle %0d required %0d", first_wr, acc_cyc + 1);
    end
    if (commits == 4) begin
      checks++;
      if (commit_cyc[2] - commit_cyc[0] != 3) begin
        errors++;
        $display("FAIL throughput: got %0d cycles/pixel required 3", commit_cyc[2] - commit_cyc[0]);
      end
      checks++;
      if (got_d[0] !== 64'h0706050403020100 || got_d[3] !== 64'h1F1E1D1C1B1A1918) begin
        errors++;
        $display("FAIL two_pix_literal: got %h %h required 0706050403020100 1f1e1d1c1b1a1918",
                 got_d[0], got_d[3]);
      end
    end
  endtask

  task automatic test_stall();
    logic [127:0] pix;
    int unsigned  commits = 0;
    bit           hit, acc;
    apply_reset();
    pix = rand_pix();
    base_addr = 16'h0200; wr_ready = 1'b0; start = 1'b1;
    step();
    start = 1'b0; ofm_valid = 1'b1; ofm_data = pix;
    hit = 1'b0;
    for (int i = 0; i < 10 && !hit; i++) begin
      @(negedge clk);
      if (s_wr_en) hit = 1'b1;
      else begin
        acc = s_ofm_ready && ofm_valid;
        step();
        if (acc) ofm_data = rand_pix();
      end
    end
    checks++;
    if (!hit) begin
      errors++; $display("FAIL stall_reach_lo: no write request within 10 cycles");
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (s_wr_en !== 1'b1 || s_wr_addr !== 16'h0200 || s_wr_data !== exp_word(pix, 0) ||
          s_ofm_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_stable[%0d]: en=%b %h@%h rdy=%b required 1 %h@0200 0",
                 i, s_wr_en, s_wr_data, s_wr_addr, s_ofm_ready, exp_word(pix, 0));
      end
      @(negedge clk);
    end
    wr_ready = 1'b1;
    if (s_wr_en && wr_ready) commits++;
    step();
    wr_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (s_wr_en && wr_ready) commits++;
      checks++;
      if (s_ofm_ready !== 1'b0) begin
        errors++; $display("FAIL stall_ready[%0d]: got %b required 0", i, s_ofm_ready);
      end
    end
    checks++;
    if (commits != 1) begin
      errors++; $display("FAIL stall_commits: got %0d required 1", commits);
    end
    checks++;
    if (s_wr_en !== 1'b1 || s_wr_addr !== 16'h0201 || s_wr_data !== exp_word(pix, 1)) begin
      errors++;
      $display("FAIL stall_hi: en=%b %h@%h required 1 %h@0201",
               s_wr_en, s_wr_data, s_wr_addr, exp_word(pix, 1));
    end
  endtask

  task automatic test_wrap();
    logic [127:0] pix;
    logic [15:0]  got_a [2];
    logic [63:0]  got_d [2];
    int unsigned  commits = 0;
    bit           acc;
    apply_reset();
    pix = rand_pix();
    base_addr = 16'hFFFF; wr_ready = 1'b1; start = 1'b1;
    step();
    start = 1'b0; ofm_valid = 1'b1; ofm_data = pix;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      acc = s_ofm_ready && ofm_valid;
      if (s_wr_en && wr_ready) begin
        if (commits < 2) begin
          got_a[commits] = s_wr_addr;
          got_d[commits] = s_wr_data;
        end
        commits++;
      end
      step();
      if (acc) ofm_valid = 1'b0;
    end
    checks++;
    if (commits != 2) begin
      errors++; $display("FAIL wrap_count: got %0d writes required 2", commits);
    end else begin
      checks++;
      if (got_a[0] !== 16'hFFFF || got_a[1] !== 16'h0000) begin
        errors++;
        $display("FAIL wrap_addr: got %h %h required ffff 0000", got_a[0], got_a[1]);
      end
      checks++;
      if (got_d[0] !== exp_word(pix, 0) || got_d[1] !== exp_word(pix, 1)) begin
        errors++;
        $display("FAIL wrap_data: got %h %h required %h %h",
                 got_d[0], got_d[1], exp_word(pix, 0), exp_word(pix, 1));
      end
    end
  endtask

  task automatic test_start_clear();
    int unsigned commits = 0, dones = 0, sent = 0;
    bit          hit, acc;
    apply_reset();
    pix_mem[0] = rand_pix();
    pix_mem[1] = rand_pix();
    base_addr = 16'h0300; wr_ready = 1'b0; start = 1'b1;
    step();
    start = 1'b0; ofm_valid = 1'b1; ofm_data = pix_mem[0];
    hit = 1'b0;
    for (int i = 0; i < 10 && !hit; i++) begin
      @(negedge clk);
      if (s_wr_en) hit = 1'b1;
      else begin
        acc = s_ofm_ready && ofm_valid;
        step();
        if (acc) begin sent++; ofm_data = pix_mem[1]; end
      end
    end
    checks++;
    if (!hit) begin
      errors++; $display("FAIL sc_reach_lo: no write request within 10 cycles");
    end
    base_addr = 16'h0555; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (s_wr_en !== 1'b1 || s_busy !== 1'b1 || s_wr_addr !== 16'h0300 ||
        s_wr_data !== exp_word(pix_mem[0], 0)) begin
      errors++;
      $display("FAIL start_ignored: en=%b busy=%b %h@%h required 1 1 %h@0300",
               s_wr_en, s_busy, s_wr_data, s_wr_addr, exp_word(pix_mem[0], 0));
    end
    wr_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (s_wr_en !== 1'b1 || s_wr_addr !== 16'h0301) begin
      errors++;
      $display("FAIL sc_hi_addr: en=%b addr=%h required 1 0301", s_wr_en, s_wr_addr);
    end
    @(negedge clk);
    wr_ready = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 10 && !hit; i++) begin
      @(negedge clk);
      if (s_wr_en) hit = 1'b1;
      else begin
        acc = s_ofm_ready && ofm_valid;
        step();
        if (acc) ofm_valid = 1'b0;
      end
    end
    ofm_valid = 1'b0;
    checks++;
    if (!hit || s_wr_addr !== 16'h0302) begin
      errors++;
      $display("FAIL sc_second_lo: seen=%b addr=%h required 1 0302", hit, s_wr_addr);
    end
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    checks++;
    if ({s_wr_en, s_busy, s_ofm_ready, s_done} !== 4'b0 || s_wr_data !== 64'h0) begin
      errors++;
      $display("FAIL clear_idle: en=%b busy=%b rdy=%b done=%b data=%h required all 0",
               s_wr_en, s_busy, s_ofm_ready, s_done, s_wr_data);
    end
    wr_ready = 1'b1; ofm_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (s_wr_en && wr_ready) commits++;
      if (s_done) dones++;
    end
    checks++;
    if (commits != 0 || dones != 0) begin
      errors++;
      $display("FAIL clear_quiet: got %0d writes %0d done required 0 0", commits, dones);
    end
    start = 1'b1; clear = 1'b1;
    @(negedge clk);
    start = 1'b0; clear = 1'b0;
    checks++;
    if (s_busy !== 1'b0) begin
      errors++; $display("FAIL clear_beats_start: busy=%b required 0", s_busy);
    end
    ofm_valid = 1'b0; wr_ready = 1'b0;
  endtask

  task automatic test_full_layer();
    int unsigned commits = 0, dones = 0, sent = 0, base;
    int          last_commit = -100, done_at = -1;
    logic [15:0] exp_a;
    logic [63:0] exp_d;
    bit          acc;
    apply_reset();
    base = $urandom_range(0, 65535);
    for (int k = 0; k < 3136; k++) pix_mem[k] = rand_pix();
    base_addr = 16'(base); start = 1'b1;
    step();
    start = 1'b0;
    for (int cyc = 0; cyc < 60000; cyc++) begin
      @(negedge clk);
      acc = l_ofm_ready && ofm_valid;
      if (l_wr_en && wr_ready) begin
        exp_a = 16'(base + commits);
        exp_d = (commits < 6272) ? exp_word(pix_mem[commits / 2], commits % 2) : 64'h0;
        checks++;
        if (commits >= 6272 || l_wr_addr !== exp_a || l_wr_data !== exp_d) begin
          errors++;
          $display("FAIL layer_write[%0d]: got %h@%h required %h@%h",
                   commits, l_wr_data, l_wr_addr, exp_d, exp_a);
        end
        commits++;
        last_commit = cyc;
      end
      if (l_done) begin
        dones++;
        done_at = cyc;
      end
      if (dones != 0 && cyc >= done_at + 4) break;
      step();
      if (acc) begin
        sent++;
        ofm_valid = 1'b0;
      end
      if (!ofm_valid && sent < 3136 && $urandom_range(0, 99) < 70) begin
        ofm_valid = 1'b1;
        ofm_data  = pix_mem[sent];
      end
      wr_ready = ($urandom_range(0, 99) < 70);
    end
    checks++;
    if (commits != 6272) begin
      errors++; $display("FAIL layer_count: got %0d writes required 6272", commits);
    end
    checks++;
    if (dones != 1 || done_at != last_commit + 1) begin
      errors++;
      $display("FAIL layer_done: got %0d pulses at cycle %0d required 1 at cycle %0d",
               dones, done_at, last_commit + 1);
    end
    checks++;
    if (l_pix_count !== 16'd3136 || l_busy !== 1'b0) begin
      errors++;
      $display("FAIL layer_final: cnt=%0d busy=%b required 3136 0", l_pix_count, l_busy);
    end
    ofm_valid = 1'b0; wr_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_two_pixels();
    test_stall();
    test_wrap();
    test_start_clear();
    test_full_layer();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
